// File: rtl/upc_scan_tx.sv
// upc_scan_tx: serializes an item word as start, data MSB first, even parity, stop.
// Optional UPC_TX_SKID_EN adds a one-entry holding register for gapless back-to-back frames.
module upc_scan_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_W       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_line,
   output logic              busy,
   output logic              frame_done
);
   localparam int BW = $clog2(CLKS_PER_BIT) + 1;
   localparam int CW = $clog2(DATA_W) + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              r_state, w_state_nxt;
   logic [BW-1:0]       r_baud, w_baud_nxt;
   logic [CW-1:0]       r_bit, w_bit_nxt;
   logic [DATA_W-1:0]   r_shift, w_shift_nxt, w_load_data, w_restart_data;
   logic                r_par, w_par_nxt;
   logic                r_tx, r_busy, r_done;
   logic                w_tx_nxt, w_busy_nxt, w_done_nxt;
   logic                w_tick, w_xfer, w_last, w_load, w_restart;

   assign w_tick = r_baud == BW'(CLKS_PER_BIT - 1);
   assign w_xfer = in_valid && in_ready;
   assign w_last = (r_state == STOP) && w_tick;

`ifdef UPC_TX_SKID_EN
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_v;
   assign in_ready       = reset && ((r_state == IDLE) || !r_hold_v);
   assign w_restart      = w_last && (r_hold_v || w_xfer);
   assign w_restart_data = r_hold_v ? r_hold : in_data;
   // A word arriving in the last stop cycle with the holding register empty bypasses it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold   <= '0;
         r_hold_v <= 1'b0;
      end else if (w_last) begin
         r_hold_v <= 1'b0;
      end else if (w_xfer && r_state != IDLE) begin
         r_hold   <= in_data;
         r_hold_v <= 1'b1;
      end
   end
`else
   assign in_ready       = reset && (r_state == IDLE);
   assign w_restart      = 1'b0;
   assign w_restart_data = in_data;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = (r_state == IDLE || w_tick) ? '0 : r_baud + BW'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_load      = 1'b0;
      w_load_data = in_data;
      case (r_state)
         IDLE: if (w_xfer) begin
            w_state_nxt = START;
            w_load      = 1'b1;
         end
         START: if (w_tick) begin
            w_state_nxt = DATA;
            w_bit_nxt   = '0;
         end
         DATA: if (w_tick) begin
            w_shift_nxt = r_shift << 1;
            w_bit_nxt   = r_bit + CW'(1);
            if (r_bit == CW'(DATA_W - 1)) w_state_nxt = PARITY;
         end
         PARITY: if (w_tick) w_state_nxt = STOP;
         STOP: if (w_tick) begin
            w_state_nxt = w_restart ? START : IDLE;
            w_load      = w_restart;
            w_load_data = w_restart_data;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_load) begin
         w_shift_nxt = w_load_data;
         w_par_nxt   = ^w_load_data;
      end
   end

   // Outputs are decoded from next-state values so they land in registers.
   always_comb begin
      w_tx_nxt   = (w_state_nxt == START)  ? 1'b0 :
                   (w_state_nxt == DATA)   ? w_shift_nxt[DATA_W-1] :
                   (w_state_nxt == PARITY) ? w_par_nxt : 1'b1;
      w_busy_nxt = w_state_nxt != IDLE;
      w_done_nxt = (w_state_nxt == STOP) && (w_baud_nxt == BW'(CLKS_PER_BIT - 1));
   end

   assign tx_line    = r_tx;
   assign busy       = r_busy;
   assign frame_done = r_done;
endmodule

// File: tb/tb_upc_scan_tx.sv
// tb_upc_scan_tx: directed checks of upc_scan_tx framing, handshake and reset behaviour.
module tb_upc_scan_tx;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] in_data = 4'b0000;
   logic       in_valid = 1'b0;
   logic       in_ready, tx_line, busy, frame_done;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   upc_scan_tx #(.CLKS_PER_BIT(4), .DATA_W(4)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .tx_line(tx_line), .busy(busy), .frame_done(frame_done)
   );

   task automatic accept(input logic [3:0] d, input string nm);
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s accept: in_ready got %b want 1 within 100 cycles", nm, in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // e holds the seven frame bits, first transmitted bit in e[6].
   task automatic frame(input logic [6:0] e, input string nm);
      for (int c = 1; c <= 28; c++) begin
         @(negedge clk);
         n_chk += 3;
         if (tx_line !== e[6-(c-1)/4]) begin
            n_fail++;
            $display("FAIL %s cycle %0d tx_line got %b want %b", nm, c, tx_line, e[6-(c-1)/4]);
         end
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s cycle %0d busy got %b want 1", nm, c, busy);
         end
         if (frame_done !== 1'(c == 28)) begin
            n_fail++;
            $display("FAIL %s cycle %0d frame_done got %b want %b", nm, c, frame_done, c == 28);
         end
      end
   endtask

   task automatic idle_check(input string nm);
      @(negedge clk);
      n_chk += 4;
      if (tx_line !== 1'b1) begin n_fail++; $display("FAIL %s idle tx_line got %b want 1", nm, tx_line); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL %s idle busy got %b want 0", nm, busy); end
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s idle frame_done got %b want 0", nm, frame_done); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle in_ready got %b want 1", nm, in_ready); end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk += 4;
         if (tx_line !== 1'b1) begin n_fail++; $display("FAIL reset tx_line got %b want 1", tx_line); end
         if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
         if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done got %b want 0", frame_done); end
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready got %b want 0", in_ready); end
      end
      reset = 1'b1;
      #1;
      n_chk += 2;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release in_ready got %b want 1", in_ready); end
      if (tx_line !== 1'b1) begin n_fail++; $display("FAIL reset_release tx_line got %b want 1", tx_line); end
   endtask

   task automatic test_basic();
      accept(4'b1010, "basic");
      frame(7'b0101001, "basic");
      idle_check("basic");
   endtask

   task automatic test_capture();
      accept(4'b0111, "capture");
      in_data = 4'b0000;
      frame(7'b0011111, "capture");
      idle_check("capture");
   endtask

   task automatic test_back_to_back();
      logic [6:0] ea, eb, e_sel;
      logic       e_tx, e_busy, e_done, e_rdy;
      int         gap, drop, k;
      ea = 7'b0000111;
      eb = 7'b0100011;
`ifdef UPC_TX_SKID_EN
      gap  = 0;
      drop = 1;
`else
      gap  = 1;
      drop = 29;
`endif
      @(negedge clk);
      in_data  = 4'b0001;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      @(posedge clk);
      #1 in_data = 4'b1000;
      for (int c = 1; c <= 57 + gap; c++) begin
         @(negedge clk);
         e_sel = ea;
         k     = c;
         if (c > 28 + gap) begin
            e_sel = eb;
            k     = c - 28 - gap;
         end
         e_busy = (c <= 28) || (c > 28 + gap && c <= 56 + gap);
         e_tx   = e_busy ? e_sel[6-(k-1)/4] : 1'b1;
         e_done = e_busy && (k == 28);
`ifdef UPC_TX_SKID_EN
         e_rdy  = (c == 1) || (c >= 29);
`else
         e_rdy  = (c == 29) || (c == 58);
`endif
         n_chk += 4;
         if (tx_line !== e_tx) begin n_fail++; $display("FAIL b2b cycle %0d tx_line got %b want %b", c, tx_line, e_tx); end
         if (busy !== e_busy) begin n_fail++; $display("FAIL b2b cycle %0d busy got %b want %b", c, busy, e_busy); end
         if (frame_done !== e_done) begin n_fail++; $display("FAIL b2b cycle %0d frame_done got %b want %b", c, frame_done, e_done); end
         if (in_ready !== e_rdy) begin n_fail++; $display("FAIL b2b cycle %0d in_ready got %b want %b", c, in_ready, e_rdy); end
         if (c == drop) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid();
      accept(4'b1010, "mid_reset");
      for (int c = 1; c <= 10; c++) @(negedge clk);
      n_chk++;
      if (tx_line !== 1'b0) begin n_fail++; $display("FAIL mid_reset pre tx_line got %b want 0", tx_line); end
      #2 reset = 1'b0;
      #1;
      n_chk += 3;
      if (tx_line !== 1'b1) begin n_fail++; $display("FAIL mid_reset async tx_line got %b want 1", tx_line); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset async busy got %b want 0", busy); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset async in_ready got %b want 0", in_ready); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_chk += 2;
         if (frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset hold frame_done got %b want 0", frame_done); end
         if (tx_line !== 1'b1) begin n_fail++; $display("FAIL mid_reset hold tx_line got %b want 1", tx_line); end
      end
      reset = 1'b1;
      accept(4'b1111, "after_reset");
      frame(7'b0111101, "after_reset");
      idle_check("after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_capture();
      test_back_to_back();
      idle_check("b2b_end");
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/upc_scan_tx.md
Name: upc_scan_tx

Overview:
Scanner-side transmitter for the checkout item word {U, P, C, Mark}.
- Accepts one DATA_W-bit item word over a valid/ready handshake.
- Serializes it onto a single wire as: start bit, data bits MSB first, even parity bit, stop bit.
- Sits between the scanner switch/FSM logic and the serial link to the checkout classifier (discounted/stolen logic) on the DE1-SoC.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range >= 1.
- DATA_W, 4, item word width; bit [DATA_W-1] is U, bit 0 is Mark.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low reset.
- in_data, input, DATA_W, item word to send.
- in_valid, input, 1, in_data is valid this cycle.
- in_ready, output, 1, block can accept a word this cycle.
- tx_line, output, 1, serial line; idles high.
- busy, output, 1, a frame is in progress (any state other than IDLE).
- frame_done, output, 1, one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (reset low, takes effect asynchronously):
  - tx_line=1, in_ready=0, busy=0, frame_done=0.
  - Baud and bit counters = 0; state = IDLE; holding register cleared.
  - First cycle after reset release: in_ready=1.
- Handshake:
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - in_data is captured on that edge into the shift register.
  - in_valid while in_ready=0 is ignored; there is no back-pressure error.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: tx_line=1, in_ready=1. On transfer -> START.
  - START: tx_line=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_W bits, MSB first, each held CLKS_PER_BIT cycles. Bit counter counts 0..DATA_W-1.
  - PARITY: tx_line = XOR of the captured word (even parity over data+parity), held CLKS_PER_BIT cycles.
  - STOP: tx_line=1 for CLKS_PER_BIT cycles. frame_done=1 in the final cycle. Next state is IDLE.
- Timing:
  - Registered outputs. tx_line changes in the cycle after the accepting edge.
  - Frame length is exactly (DATA_W+3)*CLKS_PER_BIT cycles.
  - Without the optional feature, there is a minimum 1 IDLE cycle between frames (in_ready high in that cycle).
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT)+1, counting 0..CLKS_PER_BIT-1 and wrapping at each bit boundary.
  - CLKS_PER_BIT=1 must work, giving one cycle per bit.
- Parity is computed from the captured word, not from live in_data; in_data may change after acceptance.
- Reset asserted mid-frame: tx_line returns high immediately, and the frame is abandoned with no frame_done.

Optional Feature:
UPC_TX_SKID_EN
- Defined:
  - Adds a one-entry holding register.
  - in_ready = 1 in IDLE, or whenever the holding register is empty (including during a frame).
  - A word accepted during a frame waits in the holding register.
  - At the end of STOP, if the holding register is full, go directly to START with no idle cycle, load the word, and clear the holding register. frame_done still pulses.
  - busy stays high across back-to-back frames.
- Undefined: no holding register; in_ready = (state==IDLE) only.

Test Plan:
- Reset: hold reset low 3 cycles, then release -> tx_line=1, busy=0, frame_done=0 during reset; in_ready=1 on the first cycle after release.
- Send 4'b1010 (CLKS_PER_BIT=4) -> tx_line sequence 0,1,0,1,0,0(parity),1(stop), each 4 cycles (28 cycles total); frame_done high only on cycle 28; busy high cycles 1-28.
- Send 4'b0111 -> data bits 0,1,1,1; parity bit 1; change in_data to 4'b0000 on the cycle after acceptance -> serialized bits unchanged.
- Hold in_valid=1 with 4'b0001 then 4'b1000 (feature off) -> second word accepted only in the IDLE cycle after frame 1; one idle-high cycle between frames; in_valid during busy ignored.
- Same stimulus with UPC_TX_SKID_EN -> second word accepted during frame 1; its start bit begins on the cycle right after frame 1's stop bit; total 56 cycles with busy continuously high.
- Assert reset at cycle 10 of a frame -> tx_line=1 and busy=0 asynchronously; no frame_done; the next accepted word 4'b1111 transmits cleanly with parity 0.
